regfile_dump: RTL and testbench
===============================

REGFILE_DUMP -- requirements
Module: regfile_dump

Interface
REQ-001 The module SHALL have a parameter N_REGS, default `N_REGS (32), giving the number of registers in the dumped file.
REQ-002 The module SHALL have a parameter ADRS_W, default 5, giving the register address width.
REQ-003 Port clk_cpu  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 Port reset  input  1  synchronous, active-low reset; 0 sampled at a clk_cpu edge resets the block.
REQ-005 Port start  input  1  one-cycle request to begin a dump; SHALL be honoured only in IDLE.
REQ-006 Port abort  input  1  terminates an in-progress dump.
REQ-007 Port start_adrs  input  ADRS_W  first register to dump; sampled with start.
REQ-008 Port end_adrs  input  ADRS_W  last register to dump, inclusive; sampled with start.
REQ-009 Port rd_adrs  output  ADRS_W  address driven to a combinational register-file read port.
REQ-010 Port rd_data  input  32  same-cycle read data for rd_adrs.
REQ-011 Port dump_valid  output  1  dump_data, dump_adrs and dump_last hold a beat.
REQ-012 Port dump_ready  input  1  the sink accepts the beat; a transfer is dump_valid && dump_ready.
REQ-013 Port dump_data  output  32  register value for the beat.
REQ-014 Port dump_adrs  output  ADRS_W  register index for the beat.
REQ-015 Port dump_last  output  1  the beat carries end_adrs.
REQ-016 Port busy  output  1  high in every state except IDLE.
REQ-017 Port done  output  1  one-cycle pulse marking normal completion.
REQ-018 Port checksum  output  32  mod-2^32 sum of all transferred dump_data; valid while done is high and held until the next start.

Function
REQ-019 The FSM SHALL have four states: IDLE, READ, DRAIN and DONE.
REQ-020 IDLE SHALL transition to READ on start, latching start_adrs into a counter cnt and end_adrs into end_q, and clearing checksum.
REQ-021 rd_adrs SHALL equal cnt in every state.
REQ-022 In READ, the output register SHALL load when !dump_valid || dump_ready, capturing rd_data, cnt and (cnt == end_q) into dump_data, dump_adrs and dump_last.
REQ-023 On a load in READ, cnt SHALL increment, wrapping from N_REGS-1 to 0.
REQ-024 When the loaded beat has dump_last=1, the FSM SHALL move to DRAIN.
REQ-025 DRAIN SHALL hold the beat until it is transferred, then move to DONE.
REQ-026 DONE SHALL assert done for exactly one cycle, then return to IDLE.
REQ-027 Latency SHALL be: start at cycle T gives busy=1 at T+1 and the first dump_valid at T+2.
REQ-028 With dump_ready held high, throughput SHALL be one beat per cycle with no bubbles.
REQ-029 dump_data, dump_adrs and dump_last SHALL stay stable while dump_valid && !dump_ready.
REQ-030 When start_adrs > end_adrs, the dump SHALL wrap through N_REGS-1 to 0; when start_adrs == end_adrs, exactly one beat SHALL be sent.
REQ-031 checksum SHALL add dump_data on each transfer, discard the carry, and leave unconsumed beats out of the sum.
REQ-032 On abort in READ, DRAIN or DONE, the next cycle SHALL have dump_valid=0 and state IDLE, with done not asserted.
REQ-033 Abort SHALL take priority over a simultaneous transfer, load or done; abort in IDLE SHALL have no effect.
REQ-034 start while busy SHALL be ignored; start and abort together in IDLE SHALL start a dump.
REQ-035 Each beat SHALL carry register contents as read in the cycle it loaded; a consistent snapshot of the file is not guaranteed.

Reset
REQ-036 While reset=0 at a clk_cpu edge, the block SHALL enter IDLE and drive dump_valid=0, dump_last=0, busy=0, done=0, dump_data=0, dump_adrs=0, checksum=0, cnt=0 and rd_adrs=0.
REQ-037 Reset mid-dump SHALL discard the pending beat without a done pulse; reset SHALL override start and abort.

Structure
REQ-038 The FSM state enum and a DUMP_W=32 constant SHALL live in the shared package beside `N_REGS.
REQ-039 The block SHALL be flat RTL with no sub-module instances.
REQ-040 The output register SHALL be the only data buffer.

Verification
REQ-041 Full dump: regs[i]=i*3, start with 0..31 and dump_ready=1 -> 32 contiguous beats with dump_adrs 0..31, dump_last on 31, done at T+34, checksum=1488.
REQ-042 Wrap: start 30..1 -> beats on adrs 30,31,0,1, dump_last on adrs 1.
REQ-043 Single: start 7..7, regs[7]=0xDEADBEEF -> one beat with dump_last=1, checksum=0xDEADBEEF.
REQ-044 Backpressure: dump_ready toggled 1,0,0,1 -> beat fields stable during stall, no loss or duplication, checksum matches REQ-041.
REQ-045 Abort and restart: abort after the 3rd transfer -> dump_valid=0 next cycle, no done, busy=0; a following start 0..0 works.
REQ-046 Reset and start conflicts: reset=0 mid-dump -> all outputs at reset values next cycle; start during busy -> no effect.

Source files
------------

// File: rtl/regfile_dump_pkg.sv
// Shared constants and state encoding for the register-file dump engine.
`ifndef N_REGS
`define N_REGS 32
`endif

package regfile_dump_pkg;

  localparam int DUMP_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } dump_state_e;

endpackage

// File: rtl/regfile_dump.sv
// Streams a contiguous (possibly wrapping) range of a register file out over a
// valid/ready port, accumulating a mod-2^32 checksum of the accepted beats.
module regfile_dump
  import regfile_dump_pkg::*;
#(
  parameter int N_REGS = `N_REGS,
  parameter int ADRS_W = 5
) (
  input  logic              clk_cpu,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic [ADRS_W-1:0] start_adrs,
  input  logic [ADRS_W-1:0] end_adrs,
  output logic [ADRS_W-1:0] rd_adrs,
  input  logic [DUMP_W-1:0] rd_data,
  output logic              dump_valid,
  input  logic              dump_ready,
  output logic [DUMP_W-1:0] dump_data,
  output logic [ADRS_W-1:0] dump_adrs,
  output logic              dump_last,
  output logic              busy,
  output logic              done,
  output logic [DUMP_W-1:0] checksum
);

  dump_state_e       state_r;
  logic [ADRS_W-1:0] cnt_r;
  logic [ADRS_W-1:0] end_q_r;
  logic              xfer_s;
  logic              load_s;
  logic              last_s;
  logic [ADRS_W-1:0] cnt_next_s;

  assign rd_adrs = cnt_r;

  // Handshake decode and wrapping address increment.
  always_comb begin
    xfer_s = dump_valid && dump_ready;
    load_s = (state_r == ST_READ) && (!dump_valid || dump_ready);
    last_s = (cnt_r == end_q_r);
    if (cnt_r == ADRS_W'(N_REGS - 1)) begin
      cnt_next_s = '0;
    end else begin
      cnt_next_s = cnt_r + ADRS_W'(1);
    end
  end

  // Dump FSM with the single output register; abort wins over any progress.
  always_ff @(posedge clk_cpu) begin
    if (!reset) begin
      state_r    <= ST_IDLE;
      cnt_r      <= '0;
      end_q_r    <= '0;
      dump_valid <= 1'b0;
      dump_data  <= '0;
      dump_adrs  <= '0;
      dump_last  <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      checksum   <= '0;
    end else if (abort && (state_r != ST_IDLE)) begin
      state_r    <= ST_IDLE;
      dump_valid <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      if (xfer_s) begin
        checksum <= checksum + dump_data;
      end
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            cnt_r    <= start_adrs;
            end_q_r  <= end_adrs;
            checksum <= '0;
            busy     <= 1'b1;
            state_r  <= ST_READ;
          end
        end
        ST_READ: begin
          if (load_s) begin
            dump_valid <= 1'b1;
            dump_data  <= rd_data;
            dump_adrs  <= cnt_r;
            dump_last  <= last_s;
            cnt_r      <= cnt_next_s;
            if (last_s) begin
              state_r <= ST_DRAIN;
            end
          end
        end
        ST_DRAIN: begin
          // The last beat must leave before completion is signalled.
          if (dump_ready) begin
            dump_valid <= 1'b0;
            done       <= 1'b1;
            state_r    <= ST_DONE;
          end
        end
        ST_DONE: begin
          busy    <= 1'b0;
          state_r <= ST_IDLE;
        end
        default: begin
          state_r    <= ST_IDLE;
          dump_valid <= 1'b0;
          busy       <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_dump.sv
// Randomized bench for regfile_dump: an expected-beat list built from the
// address range drives a per-cycle scoreboard, plus hand-computed literals.
`timescale 1ns/1ps
module tb_regfile_dump;
  import regfile_dump_pkg::*;

  localparam int NR = 32;
  localparam int AW = 5;

  logic          clk_cpu = 1'b0;
  logic          reset, start, abort, dump_ready;
  logic [AW-1:0] start_adrs, end_adrs, rd_adrs, dump_adrs;
  logic [31:0]   rd_data, dump_data, checksum;
  logic          dump_valid, dump_last, busy, done;

  logic [31:0] regs [NR];
  int tests = 0;
  int fails = 0;

  typedef struct {
    int          adrs;
    logic [31:0] data;
    bit          last;
  } beat_t;

  beat_t       exp_q[$];
  logic [31:0] exp_sum;
  int          xfer_cnt;
  int          obs_adrs[$];
  bit          obs_last[$];
  int          ready_mode = 0;
  int          pat_idx = 0;

  logic          prev_stall = 1'b0;
  logic [31:0]   prev_data;
  logic [AW-1:0] prev_adrs;
  logic          prev_last;

  regfile_dump dut (
    .clk_cpu(clk_cpu), .reset(reset), .start(start), .abort(abort),
    .start_adrs(start_adrs), .end_adrs(end_adrs), .rd_adrs(rd_adrs),
    .rd_data(rd_data), .dump_valid(dump_valid), .dump_ready(dump_ready),
    .dump_data(dump_data), .dump_adrs(dump_adrs), .dump_last(dump_last),
    .busy(busy), .done(done), .checksum(checksum)
  );

  always #5 clk_cpu = ~clk_cpu;

  assign rd_data = regs[rd_adrs];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Expected beats are simply every address from s to e, wrapping at NR.
  task automatic build(input int s, input int e);
    int a;
    exp_q.delete();
    obs_adrs.delete();
    obs_last.delete();
    exp_sum  = 32'd0;
    xfer_cnt = 0;
    a = s;
    for (int k = 0; k < NR; k++) begin
      exp_q.push_back('{adrs: a, data: regs[a], last: (a == e)});
      if (a == e) break;
      a = (a + 1) % NR;
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_valid"}, dump_valid, 1'b0);
    check({tag, "_last"}, dump_last, 1'b0);
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_done"}, done, 1'b0);
    check({tag, "_data"}, dump_data, 32'd0);
    check({tag, "_adrs"}, dump_adrs, 5'd0);
    check({tag, "_checksum"}, checksum, 32'd0);
    check({tag, "_rd_adrs"}, rd_adrs, 5'd0);
  endtask

  // Sink ready pattern: always, random, or the repeating 1,0,0,1 sequence.
  initial begin
    dump_ready = 1'b1;
    forever begin
      @(posedge clk_cpu); #1;
      case (ready_mode)
        0:       dump_ready = 1'b1;
        1:       dump_ready = 1'($urandom_range(0, 1));
        default: begin
          dump_ready = ((pat_idx % 4) == 0) || ((pat_idx % 4) == 3);
          pat_idx++;
        end
      endcase
    end
  end

  // Scoreboard: every visible beat must match the head of the expected list.
  always @(negedge clk_cpu) begin
    if (reset === 1'b1) begin
      if (prev_stall) begin
        check("stall_valid", dump_valid, 1'b1);
        check("stall_data", dump_data, prev_data);
        check("stall_adrs", dump_adrs, prev_adrs);
        check("stall_last", dump_last, prev_last);
      end
      if (dump_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_beat", 1'b1, 1'b0);
        end else begin
          check("beat_adrs", dump_adrs, exp_q[0].adrs);
          check("beat_data", dump_data, exp_q[0].data);
          check("beat_last", dump_last, exp_q[0].last);
          if (dump_ready && !abort) begin
            exp_sum = exp_sum + exp_q[0].data;
            obs_adrs.push_back(int'(dump_adrs));
            obs_last.push_back(dump_last);
            void'(exp_q.pop_front());
            xfer_cnt++;
          end
        end
      end
      if (done) begin
        check("done_checksum", checksum, exp_sum);
        check("done_all_sent", exp_q.size(), 0);
      end
      prev_stall = dump_valid && !dump_ready && !abort;
      prev_data  = dump_data;
      prev_adrs  = dump_adrs;
      prev_last  = dump_last;
    end else begin
      prev_stall = 1'b0;
    end
  end

  // One dump from s..e; exp_done is the expected done cycle relative to start (-1 = any).
  task automatic run_dump(input int s, input int e, input int exp_done,
                          input bit with_abort, input int poke);
    int cyc;
    bit got;
    build(s, e);
    @(posedge clk_cpu); #1;
    start_adrs = AW'(s);
    end_adrs   = AW'(e);
    start      = 1'b1;
    abort      = with_abort;
    @(posedge clk_cpu); #1;
    start = 1'b0;
    abort = 1'b0;
    check("busy_at_t1", busy, 1'b1);
    check("valid_at_t1", dump_valid, 1'b0);
    @(posedge clk_cpu); #1;
    check("valid_at_t2", dump_valid, 1'b1);
    cyc = 2;
    got = 1'b0;
    while (cyc < 400 && !got) begin
      if (cyc == poke) begin
        start      = 1'b1;
        start_adrs = 5'd10;
        end_adrs   = 5'd12;
      end else begin
        start = 1'b0;
      end
      @(posedge clk_cpu); #1;
      cyc++;
      if (done) got = 1'b1;
    end
    start = 1'b0;
    check("done_seen", got, 1'b1);
    if (exp_done >= 0) check("done_latency", cyc, exp_done);
    @(posedge clk_cpu); #1;
    check("done_one_cycle", done, 1'b0);
    check("idle_after_done", busy, 1'b0);
    @(posedge clk_cpu); #1;
    check("checksum_held", checksum, exp_sum);
  endtask

  initial begin
    int ok;
    int n;
    int s;
    int e;
    int wrap_exp[4];
    wrap_exp = '{30, 31, 0, 1};
    reset = 1'b0; start = 1'b0; abort = 1'b0;
    start_adrs = 5'd0; end_adrs = 5'd0;
    for (int i = 0; i < NR; i++) regs[i] = 32'(i * 3);
    repeat (2) @(posedge clk_cpu);
    #1;
    check_reset_values("reset");
    reset = 1'b1;

    // Full dump with ready held high.
    ready_mode = 0;
    run_dump(0, 31, 34, 1'b0, -1);
    check("full_checksum_literal", checksum, 32'd1488);
    check("full_count", obs_adrs.size(), 32);
    ok = 1;
    for (int i = 0; i < obs_adrs.size(); i++) begin
      if (obs_adrs[i] != i || obs_last[i] != (i == 31)) ok = 0;
    end
    check("full_order", ok, 1);

    // Wrapping range.
    run_dump(30, 1, 6, 1'b0, -1);
    check("wrap_count", obs_adrs.size(), 4);
    for (int i = 0; i < 4 && i < obs_adrs.size(); i++) begin
      check("wrap_adrs", obs_adrs[i], wrap_exp[i]);
      check("wrap_last", obs_last[i], (i == 3));
    end

    // Single register.
    regs[7] = 32'hDEADBEEF;
    run_dump(7, 7, 3, 1'b0, -1);
    check("single_checksum_literal", checksum, 32'hDEADBEEF);
    check("single_last", (obs_last.size() == 1) && obs_last[0], 1'b1);
    regs[7] = 32'd21;

    // Backpressure 1,0,0,1.
    ready_mode = 2;
    pat_idx = 0;
    run_dump(0, 31, -1, 1'b0, -1);
    check("bp_checksum_literal", checksum, 32'd1488);
    ready_mode = 0;

    // Start while busy is ignored; start with abort in IDLE still starts.
    run_dump(0, 31, 34, 1'b0, 5);
    check("poke_checksum_literal", checksum, 32'd1488);
    run_dump(5, 9, 7, 1'b1, -1);

    // Abort after the third transfer, then a fresh 0..0 dump.
    build(0, 31);
    @(posedge clk_cpu); #1;
    start_adrs = 5'd0; end_adrs = 5'd31; start = 1'b1;
    @(posedge clk_cpu); #1;
    start = 1'b0;
    n = 0;
    while (xfer_cnt < 3 && n < 50) begin
      @(posedge clk_cpu); #1;
      n++;
    end
    check("abort_reached_3", xfer_cnt, 3);
    abort = 1'b1;
    @(posedge clk_cpu); #1;
    abort = 1'b0;
    exp_q.delete();
    check("abort_valid", dump_valid, 1'b0);
    check("abort_busy", busy, 1'b0);
    check("abort_done", done, 1'b0);
    ok = 1;
    repeat (4) begin
      @(posedge clk_cpu); #1;
      if (done || busy || dump_valid) ok = 0;
    end
    check("abort_quiet", ok, 1);
    abort = 1'b1;
    @(posedge clk_cpu); #1;
    abort = 1'b0;
    check("abort_idle_noop", busy, 1'b0);
    regs[0] = 32'h12345678;
    run_dump(0, 0, 3, 1'b0, -1);
    check("restart_checksum_literal", checksum, 32'h12345678);
    regs[0] = 32'd0;

    // Reset in the middle of a dump.
    build(3, 20);
    @(posedge clk_cpu); #1;
    start_adrs = 5'd3; end_adrs = 5'd20; start = 1'b1;
    @(posedge clk_cpu); #1;
    start = 1'b0;
    repeat (4) @(posedge clk_cpu);
    #1;
    reset = 1'b0; start = 1'b1; abort = 1'b1;
    @(posedge clk_cpu); #1;
    check_reset_values("midreset");
    reset = 1'b1; start = 1'b0; abort = 1'b0;
    exp_q.delete();
    ok = 1;
    repeat (3) begin
      @(posedge clk_cpu); #1;
      if (done || busy || dump_valid) ok = 0;
    end
    check("midreset_quiet", ok, 1);

    // Randomized ranges, data and sink behaviour.
    for (int t = 0; t < 12; t++) begin
      for (int i = 0; i < NR; i++) regs[i] = $urandom;
      s = $urandom_range(0, NR - 1);
      e = $urandom_range(0, NR - 1);
      n = ((e - s + NR) % NR) + 1;
      ready_mode = $urandom_range(0, 1);
      run_dump(s, e, (ready_mode == 0) ? n + 2 : -1, 1'b0, -1);
      check("rand_count", obs_adrs.size(), n);
    end
    ready_mode = 0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
